// File: rtl/sobel_pixel_streamer.sv
// Raster-order pixel source for the Sobel line-buffer chain, reading a synchronous frame memory.
// Define SOBEL_STREAMER_ZERO_PAD_EN to emit the frame wrapped in a one-pixel zero border.
module sobel_pixel_streamer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
`ifdef SOBEL_STREAMER_ZERO_PAD_EN
    localparam int PAD   = 2,
`else
    localparam int PAD   = 0,
`endif
    localparam int PW    = IMG_W + PAD,
    localparam int PH    = IMG_H + PAD,
    localparam int ROW_W = (PH > 1) ? $clog2(PH) : 1,
    localparam int COL_W = (PW > 1) ? $clog2(PW) : 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    output logic              MemRd,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic              Enable,
    output logic [DATA_W-1:0] DataOut,
    output logic [ROW_W-1:0]  Row,
    output logic [COL_W-1:0]  Col,
    output logic              Busy,
    output logic              Done
);

    localparam int TOTAL = PW * PH;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  iss_cnt;
    logic [CNT_W-1:0]  emit_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  em_row;
    logic [COL_W-1:0]  em_col;
    logic              rd_pending;
    logic              hold_valid;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] src_data;
    logic [DATA_W-1:0] emit_data;
    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              emit;
    logic              last_emit;

    // Done is still high in the first IDLE cycle, so a Start there is not taken.
    assign accept     = (state == S_IDLE) && Start && !Done;
    assign issue      = (state == S_STREAM) && !Stall && !hold_valid && (iss_cnt < CNT_W'(TOTAL));
    assign last_issue = issue && (iss_cnt == CNT_W'(TOTAL - 1));
    assign emit       = !Stall && (hold_valid || rd_pending);
    assign last_emit  = emit && (emit_cnt == CNT_W'(TOTAL - 1));
    assign emit_data  = hold_valid ? hold : src_data;
    assign MemAddr    = rd_addr;

`ifdef SOBEL_STREAMER_ZERO_PAD_EN
    logic [ROW_W-1:0] fetch_row;
    logic [COL_W-1:0] fetch_col;
    logic             interior;
    logic             pad_pending;

    // Border slots travel through the same two-cycle pipeline as reads but carry zero.
    assign interior = (fetch_row != '0) && (fetch_row <= ROW_W'(IMG_H)) &&
                      (fetch_col != '0) && (fetch_col <= COL_W'(IMG_W));
    assign MemRd    = issue && interior;
    assign src_data = pad_pending ? '0 : MemData;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_row   <= '0;
            fetch_col   <= '0;
            pad_pending <= 1'b0;
        end else begin
            pad_pending <= issue && !interior;
            if (accept) begin
                fetch_row <= '0;
                fetch_col <= '0;
            end else if (issue) begin
                if (fetch_col == COL_W'(PW - 1)) begin
                    fetch_col <= '0;
                    fetch_row <= fetch_row + 1'b1;
                end else begin
                    fetch_col <= fetch_col + 1'b1;
                end
            end
        end
    end
`else
    assign MemRd    = issue;
    assign src_data = MemData;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            iss_cnt <= '0;
            rd_addr <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_STREAM;
                        Busy  <= 1'b1;
                    end
                end
                S_STREAM: if (last_issue) state <= S_FLUSH;
                S_FLUSH:  if (last_emit)  state <= S_DONE;
                default: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
            if (accept) begin
                iss_cnt <= '0;
                rd_addr <= '0;
            end else begin
                if (issue) iss_cnt <= iss_cnt + 1'b1;
                if (MemRd) rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Emit stage: a stalled read is parked in hold and replayed before the next read is issued.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rd_pending <= 1'b0;
            hold_valid <= 1'b0;
            Enable     <= 1'b0;
            DataOut    <= '0;
            emit_cnt   <= '0;
            em_row     <= '0;
            em_col     <= '0;
            Row        <= '0;
            Col        <= '0;
        end else begin
            rd_pending <= issue;
            if (emit) begin
                Enable     <= 1'b1;
                DataOut    <= emit_data;
                hold_valid <= 1'b0;
            end else if (Stall && rd_pending) begin
                Enable     <= 1'b0;
                hold_valid <= 1'b1;
            end else begin
                Enable <= 1'b0;
            end

            if (accept) begin
                emit_cnt <= '0;
                em_row   <= '0;
                em_col   <= '0;
                Row      <= '0;
                Col      <= '0;
            end else if (emit) begin
                Row      <= em_row;
                Col      <= em_col;
                emit_cnt <= emit_cnt + 1'b1;
                if (em_col == COL_W'(PW - 1)) begin
                    em_col <= '0;
                    em_row <= em_row + 1'b1;
                end else begin
                    em_col <= em_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Stall && rd_pending) hold <= src_data;
    end

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Self-checking bench for sobel_pixel_streamer on a 4x3 frame with a scoreboard of the raster pixel order.
module tb_sobel_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int AW = 4;
`ifdef SOBEL_STREAMER_ZERO_PAD_EN
    localparam int PAD = 2;
`else
    localparam int PAD = 0;
`endif
    localparam int PW    = W + PAD;
    localparam int PH    = H + PAD;
    localparam int TOTAL = PW * PH;
    localparam int RW    = (PH > 1) ? $clog2(PH) : 1;
    localparam int CW    = (PW > 1) ? $clog2(PW) : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          enable;
    logic [DW-1:0] data_out;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_assert = 0;
    int n_fail   = 0;

    sobel_pixel_streamer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(clk), .Reset(rst), .Start(start), .Stall(stall),
        .MemRd(mem_rd), .MemAddr(mem_addr), .MemData(mem_data),
        .Enable(enable), .DataOut(data_out), .Row(row), .Col(col),
        .Busy(busy), .Done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame memory, one cycle of latency.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Expected value of the idx-th emitted pixel in padded raster order.
    function automatic logic [31:0] exp_pix(input int idx);
        int r, c;
        r = idx / PW;
        c = idx % PW;
        if (PAD == 0) return 32'(mem[idx]);
        if (r >= 1 && r <= H && c >= 1 && c <= W) return 32'(mem[(r - 1) * W + (c - 1)]);
        return 32'd0;
    endfunction

    task automatic fill_inc();
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a + 1);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom_range(255));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_dataout"}, data_out, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_memrd"}, mem_rd, 0);
        chk({tag, "_memaddr"}, mem_addr, 0);
    endtask

    task automatic run_frame(input string name, input int stall_pct, input int stall_at,
                             input int stall_len, input bit extra_starts, input int abort_after);
        int  k = 0;
        int  cyc = 0;
        int  first_en = -1;
        int  last_en = -1;
        int  done_cyc = -1;
        int  busy_cnt = 0;
        bit  prev_stall = 1'b0;
        stall = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_busy_on_accept"}, busy, 1);
        while (done_cyc < 0 && cyc < 600) begin
            if (busy) busy_cnt++;
            if (prev_stall) chk({name, "_no_enable_after_stall"}, enable, 0);
            if (enable) begin
                if (k < TOTAL) begin
                    chk({name, "_data"}, data_out, exp_pix(k));
                    chk({name, "_row"}, row, k / PW);
                    chk({name, "_col"}, col, k % PW);
                end else begin
                    chk({name, "_extra_enable"}, k, TOTAL - 1);
                end
                k++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (stall_len > 0 && cyc == stall_at + stall_len) begin
                chk({name, "_held_emit"}, enable, 1);
                chk({name, "_held_value"}, data_out, exp_pix(stall_at - 2));
            end
            if (stall_len > 0 && cyc == stall_at + stall_len + 1)
                chk({name, "_one_bubble"}, enable, 0);
            if (done) begin
                done_cyc = cyc;
            end else if (abort_after > 0 && k == abort_after) begin
                return;
            end else begin
                if (stall_pct > 0) stall = ($urandom_range(99) < stall_pct);
                else stall = (stall_len > 0) && (cyc + 1 >= stall_at) && (cyc + 1 < stall_at + stall_len);
                start = extra_starts && (cyc == 4);
                prev_stall = stall;
                #1;
                if (stall) chk({name, "_no_memrd_while_stalled"}, mem_rd, 0);
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        stall = 1'b0;
        if (done_cyc < 0) begin
            chk({name, "_done_timeout"}, done, 1);
            return;
        end
        chk({name, "_pixel_count"}, k, TOTAL);
        chk({name, "_done_after_last_enable"}, done_cyc, last_en + 1);
        chk({name, "_busy_low_with_done"}, busy, 0);
        if (stall_pct == 0 && stall_len == 0) begin
            chk({name, "_first_enable_latency"}, first_en, 2);
            chk({name, "_done_cycle"}, done_cyc, TOTAL + 2);
            chk({name, "_busy_done_window"}, busy_cnt + 1, TOTAL + 3);
        end
        if (stall_len > 0) chk({name, "_stalled_done_cycle"}, done_cyc, TOTAL + 3 + stall_len);
        start = extra_starts;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_done_one_cycle"}, done, 0);
        for (int i = 0; i < 3; i++) begin
            chk({name, "_idle_busy"}, busy, 0);
            chk({name, "_idle_enable"}, enable, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stall_enable", enable, 0);
        chk("idle_stall_busy", busy, 0);
        chk("idle_stall_memrd", mem_rd, 0);
        stall = 1'b0;

        fill_inc();
        run_frame("plain", 0, 0, 0, 1'b0, 0);
        run_frame("stall3", 0, 6, 3, 1'b0, 0);
        run_frame("stall1", 0, 8, 1, 1'b0, 0);
        run_frame("restart_ignored", 0, 0, 0, 1'b1, 0);

        run_frame("abort", 0, 0, 0, 1'b0, 6);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame("after_reset", 0, 0, 0, 1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            fill_rand();
            run_frame("random", 30, 0, 0, 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
